// File: rtl/kt8_dmem_sys_pkg.sv
// kt8_dmem_sys_pkg: I/O register offsets, CTRL/STAT bit indices and default widths
package kt8_dmem_sys_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam logic [2:0] OFS_OUT  = 3'd0;
  localparam logic [2:0] OFS_IN   = 3'd1;
  localparam logic [2:0] OFS_CNT  = 3'd2;
  localparam logic [2:0] OFS_CMP  = 3'd3;
  localparam logic [2:0] OFS_CTRL = 3'd4;
  localparam logic [2:0] OFS_STAT = 3'd5;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;
  localparam int STAT_MATCH = 0;
endpackage

// File: rtl/kt8_timer.sv
// kt8_timer: prescaled compare timer with match flag and registered interrupt
module kt8_timer
  import kt8_dmem_sys_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TMR_PRESC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_cnt_i,
  input  logic              we_cmp_i,
  input  logic              we_ctrl_i,
  input  logic              we_stat_i,
  output logic [DATA_W-1:0] cnt_o,
  output logic [DATA_W-1:0] cmp_o,
  output logic [2:0]        ctrl_o,
  output logic              match_o,
  output logic              irq_o
);
  localparam int PW = TMR_PRESC > 1 ? $clog2(TMR_PRESC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TMR_PRESC - 1);
  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              match_q, match_d, irq_q, irq_d;
  logic              en, tick, hit;
  // A CTRL write clearing EN stops the timer on that very edge; a CNT write overrides the tick
  always_comb begin
    en      = ctrl_q[CTRL_EN] & ~(we_ctrl_i & ~wdata_i[CTRL_EN]);
    tick    = en & (presc_q == P_LAST);
    hit     = tick & ~we_cnt_i & (cnt_q == cmp_q);
    presc_d = (!en || presc_q == P_LAST) ? '0 : presc_q + 1'b1;
    cnt_d   = we_cnt_i ? wdata_i : !tick ? cnt_q : (hit && ctrl_q[CTRL_CLR]) ? '0 : cnt_q + 1'b1;
    cmp_d   = we_cmp_i ? wdata_i : cmp_q;
    ctrl_d  = we_ctrl_i ? wdata_i[2:0] : ctrl_q;
    match_d = hit | (match_q & ~(we_stat_i & wdata_i[STAT_MATCH]));
    irq_d   = match_q & ctrl_q[CTRL_IE];
  end
  // Timer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      match_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      irq_q   <= irq_d;
    end
  end
  assign cnt_o   = cnt_q;
  assign cmp_o   = cmp_q;
  assign ctrl_o  = ctrl_q;
  assign match_o = match_q;
  assign irq_o   = irq_q;
endmodule

// File: rtl/kt8_dmem_sys.sv
// kt8_dmem_sys: KT8 data space with RAM, output port, synchronised input port and timer
module kt8_dmem_sys
  import kt8_dmem_sys_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAM_DEPTH = 16,
  parameter int TMR_PRESC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              we_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [DATA_W-1:0] gpio_i,
  output logic [DATA_W-1:0] gpio_o,
  output logic              irq_o
);
  localparam int RAM_AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0] IO_LO = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0] IO_HI = (ADDR_W + 1)'(RAM_DEPTH + 8);
  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] out_q, out_d, sync1_q, sync2_q, io_rd;
  logic [DATA_W-1:0] cnt, cmp;
  logic [2:0]        ctrl, ofs;
  logic              match, in_ram, io_sel, io_we;
  logic              we_cnt, we_cmp, we_ctrl, we_stat;
  // Address decode, write strobes and the combinational read mux
  always_comb begin
    in_ram  = {1'b0, address_i} < IO_LO;
    io_sel  = !in_ram && ({1'b0, address_i} < IO_HI);
    ofs     = address_i[2:0] - 3'(RAM_DEPTH);
    io_we   = we_i & io_sel;
    we_cnt  = io_we & (ofs == OFS_CNT);
    we_cmp  = io_we & (ofs == OFS_CMP);
    we_ctrl = io_we & (ofs == OFS_CTRL);
    we_stat = io_we & (ofs == OFS_STAT);
    out_d   = (io_we && ofs == OFS_OUT) ? data_i : out_q;
    io_rd   = ofs == OFS_OUT  ? out_q :
              ofs == OFS_IN   ? sync2_q :
              ofs == OFS_CNT  ? cnt :
              ofs == OFS_CMP  ? cmp :
              ofs == OFS_CTRL ? DATA_W'(ctrl) :
              ofs == OFS_STAT ? DATA_W'(match) : '0;
    data_o  = in_ram ? mem[address_i[RAM_AW-1:0]] : io_sel ? io_rd : '0;
  end
  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (we_i && in_ram) mem[address_i[RAM_AW-1:0]] <= data_i;
  end
  // Output port register and two-flop input synchroniser
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      out_q   <= out_d;
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end
  kt8_timer #(.DATA_W(DATA_W), .TMR_PRESC(TMR_PRESC)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wdata_i   (data_i),
    .we_cnt_i  (we_cnt),
    .we_cmp_i  (we_cmp),
    .we_ctrl_i (we_ctrl),
    .we_stat_i (we_stat),
    .cnt_o     (cnt),
    .cmp_o     (cmp),
    .ctrl_o    (ctrl),
    .match_o   (match),
    .irq_o     (irq_o)
  );
  assign gpio_o = out_q;
endmodule
